// File: rtl/hafsa_sopc_cpu_debug_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// hafsa_sopc_cpu_debug_cmd_queue_if
// Bundles the TCK-side command inputs and the system-side dispatch outputs
// of the JTAG debug command queue.
//   slave  : the queue (receives ir_in/sr/strobes/ack/clr_err, drives results)
//   master : the environment / CPU side (the mirror image)
// Signals:
//   ir_in, sr, vs_udr, vs_uir    TCK-domain command and update strobes
//   action_ack, clr_err          CPU-side acknowledge and sticky-flag clear
//   jdo, take_action,
//   take_no_action               dispatched command data and one-hot pulses
//   cmd_pending, overflow,
//   parity_err                   status
// ---------------------------------------------------------------------------
interface hafsa_sopc_cpu_debug_cmd_queue_if #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2
);
  localparam int NCH = 2**IR_W;

  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              vs_udr;
  logic              vs_uir;
  logic              action_ack;
  logic              clr_err;
  logic [DATA_W-1:0] jdo;
  logic [NCH-1:0]    take_action;
  logic [NCH-1:0]    take_no_action;
  logic              cmd_pending;
  logic              overflow;
  logic              parity_err;

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, action_ack, clr_err,
    output jdo, take_action, take_no_action, cmd_pending, overflow, parity_err
  );

  modport master (
    output ir_in, sr, vs_udr, vs_uir, action_ack, clr_err,
    input  jdo, take_action, take_no_action, cmd_pending, overflow, parity_err
  );
endinterface

// File: rtl/hafsa_sopc_cpu_debug_cmd_queue.sv
// ---------------------------------------------------------------------------
// hafsa_sopc_cpu_debug_cmd_queue
// System-clock side of the CPU JTAG debug path. The asynchronous update-DR /
// update-IR levels are synchronised and edge-detected; each edge captures
// {kind, ir_in, sr} into a DEPTH-entry FIFO. A small FSM pops entries and
// issues a one-hot, single-cycle take_action (UDR) or take_no_action (UIR)
// pulse on channel ir, with jdo holding the data of the last UDR dispatched.
// Channels selected by ACK_MASK hold further dispatch until action_ack.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    hafsa_sopc_cpu_debug_cmd_queue_if.slave (see interface file)
//
// Optional feature macro: DBG_CMD_PARITY_EN
//   Defined : sr[DATA_W-1] is even parity over the rest; failing UDR entries
//             are popped without dispatch and set sticky parity_err.
//   Undefined: no check, parity_err stays 0.
// ---------------------------------------------------------------------------
module hafsa_sopc_cpu_debug_cmd_queue #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2,
  parameter int DEPTH  = 4,
  parameter logic [(2**IR_W)-1:0] ACK_MASK = '0
) (
  input logic clk,
  input logic reset,
  hafsa_sopc_cpu_debug_cmd_queue_if.slave bus
);

  localparam int NCH = 2**IR_W;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // -------------------------------------------------------------------------
  // Strobe synchronisers. Reset to 1 so a level held high through reset is
  // not mistaken for a fresh rising edge.
  // -------------------------------------------------------------------------
  logic r_udr_s1, r_udr_s2, r_udr_d;
  logic r_uir_s1, r_uir_s2, r_uir_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_udr_s1 <= 1'b1;
      r_udr_s2 <= 1'b1;
      r_udr_d  <= 1'b1;
      r_uir_s1 <= 1'b1;
      r_uir_s2 <= 1'b1;
      r_uir_d  <= 1'b1;
    end else begin
      r_udr_s1 <= bus.vs_udr;
      r_udr_s2 <= r_udr_s1;
      r_udr_d  <= r_udr_s2;
      r_uir_s1 <= bus.vs_uir;
      r_uir_s2 <= r_uir_s1;
      r_uir_d  <= r_uir_s2;
    end
  end

  logic              w_udr_edge, w_uir_edge, w_push, w_collide;
  logic [DATA_W-1:0] w_push_data;

  assign w_udr_edge  = r_udr_s2 & ~r_udr_d;
  assign w_uir_edge  = r_uir_s2 & ~r_uir_d;
  assign w_push      = w_udr_edge | w_uir_edge;
  // UDR takes priority when both strobes land together; the UIR is lost.
  assign w_collide   = w_udr_edge & w_uir_edge;
  assign w_push_data = w_udr_edge ? bus.sr : '0;

  // -------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit for full/empty.
  // -------------------------------------------------------------------------
  logic              r_mem_kind [DEPTH];   // 1 = UDR, 0 = UIR
  logic [IR_W-1:0]   r_mem_ir   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;

  logic              w_empty, w_full, w_pop, w_wr_en, w_drop;
  logic              w_head_kind;
  logic [IR_W-1:0]   w_head_ir;
  logic [DATA_W-1:0] w_head_data;
  logic              w_par_bad;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign w_head_kind = r_mem_kind[r_rd_ptr[AW-1:0]];
  assign w_head_ir   = r_mem_ir[r_rd_ptr[AW-1:0]];
  assign w_head_data = r_mem_data[r_rd_ptr[AW-1:0]];

`ifdef DBG_CMD_PARITY_EN
  assign w_par_bad = w_head_kind && (^w_head_data);
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_kind[r_wr_ptr[AW-1:0]] <= w_udr_edge;
      r_mem_ir[r_wr_ptr[AW-1:0]]   <= bus.ir_in;
      r_mem_data[r_wr_ptr[AW-1:0]] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Dispatch FSM with registered outputs.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_jdo, w_jdo_nxt;
  logic [NCH-1:0]    r_take_action, w_ta_nxt;
  logic [NCH-1:0]    r_take_no_action, w_tna_nxt;
  logic [IR_W-1:0]   r_cur_ir, w_cur_ir_nxt;
  logic              r_cur_kind, w_cur_kind_nxt;
  logic              w_par_set;
  logic              r_overflow, r_parity_err;

  always_comb begin
    w_state_nxt    = r_state;
    w_jdo_nxt      = r_jdo;
    w_ta_nxt       = '0;
    w_tna_nxt      = '0;
    w_cur_ir_nxt   = r_cur_ir;
    w_cur_kind_nxt = r_cur_kind;
    w_par_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_cur_ir_nxt   = w_head_ir;
          w_cur_kind_nxt = w_head_kind;
          if (w_par_bad) begin
            w_par_set   = 1'b1;
            w_state_nxt = S_DROP;
          end else begin
            if (w_head_kind) begin
              w_jdo_nxt = w_head_data;
              w_ta_nxt  = ONE_HOT0 << w_head_ir;
            end else begin
              w_tna_nxt = ONE_HOT0 << w_head_ir;
            end
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = (ACK_MASK[r_cur_ir] && r_cur_kind) ? S_WAIT_ACK : S_IDLE;
      end
      S_WAIT_ACK: begin
        if (bus.action_ack) w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_cur_ir         <= '0;
      r_cur_kind       <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_jdo            <= w_jdo_nxt;
      r_take_action    <= w_ta_nxt;
      r_take_no_action <= w_tna_nxt;
      r_cur_ir         <= w_cur_ir_nxt;
      r_cur_kind       <= w_cur_kind_nxt;
    end
  end

  // Sticky error flags: a new error event wins over clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_drop || w_collide) r_overflow <= 1'b1;
      else if (bus.clr_err)    r_overflow <= 1'b0;
      if (w_par_set)           r_parity_err <= 1'b1;
      else if (bus.clr_err)    r_parity_err <= 1'b0;
    end
  end

  assign bus.jdo            = r_jdo;
  assign bus.take_action    = r_take_action;
  assign bus.take_no_action = r_take_no_action;
  assign bus.cmd_pending    = !w_empty || (r_state != S_IDLE);
  assign bus.overflow       = r_overflow;
  assign bus.parity_err     = r_parity_err;

endmodule

// File: tb/tb_hafsa_sopc_cpu_debug_cmd_queue.sv
// ---------------------------------------------------------------------------
// Directed testbench for hafsa_sopc_cpu_debug_cmd_queue (DEPTH=4, IR_W=2,
// ACK_MASK=4'b0100). Inputs change and outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_hafsa_sopc_cpu_debug_cmd_queue;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  hafsa_sopc_cpu_debug_cmd_queue_if #(.DATA_W(38), .IR_W(2)) dbg ();

  hafsa_sopc_cpu_debug_cmd_queue #(
    .DATA_W  (38),
    .IR_W    (2),
    .DEPTH   (4),
    .ACK_MASK(4'b0100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Makes a data word acceptable to the parity-checking build.
  function automatic logic [37:0] mk(input logic [37:0] x);
`ifdef DBG_CMD_PARITY_EN
    return {^x[36:0], x[36:0]};
`else
    return x;
`endif
  endfunction

  // Strobe high for 2 cycles then low for 2; returns 4 clocks after the rise,
  // which is when the pulse appears if the FSM was idle.
  task automatic send(input bit uir, input logic [1:0] ir, input logic [37:0] d);
    dbg.ir_in = ir;
    dbg.sr    = d;
    if (uir) dbg.vs_uir = 1'b1;
    else     dbg.vs_udr = 1'b1;
    tick(2);
    dbg.vs_udr = 1'b0;
    dbg.vs_uir = 1'b0;
    tick(2);
  endtask

  logic [37:0] d1, d2a, d2b, x1, y;
  logic [37:0] d3 [6];
  bit          seen;

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset          = 1'b1;
    dbg.ir_in      = '0;
    dbg.sr         = '0;
    dbg.vs_udr     = 1'b0;
    dbg.vs_uir     = 1'b0;
    dbg.action_ack = 1'b0;
    dbg.clr_err    = 1'b0;
    d1  = mk(38'h15_5555_5555);
    d2a = mk(38'h00_0000_0A0A);
    d2b = mk(38'h00_0000_0B0B);
    x1  = mk(38'h0A_BCDE_F012);
    y   = 38'h3;
    for (int k = 0; k < 6; k++) d3[k] = mk(38'h100 + 38'(k));

    tick(3);
    reset = 1'b0;
    chk("rst_ta",   dbg.take_action, 4'b0000);
    chk("rst_tna",  dbg.take_no_action, 4'b0000);
    chk("rst_jdo",  dbg.jdo, 38'h0);
    chk("rst_pend", dbg.cmd_pending, 1'b0);
    chk("rst_ovf",  dbg.overflow, 1'b0);
    chk("rst_par",  dbg.parity_err, 1'b0);
    tick(2);

    // 1: basic UDR dispatch, 4-clock latency
    dbg.ir_in  = 2'd1;
    dbg.sr     = d1;
    dbg.vs_udr = 1'b1;
    tick(2);
    dbg.vs_udr = 1'b0;
    tick(1);
    chk("t1_early_ta", dbg.take_action, 4'b0000);
    chk("t1_pend_q",   dbg.cmd_pending, 1'b1);
    tick(1);
    chk("t1_ta",   dbg.take_action, 4'b0010);
    chk("t1_tna",  dbg.take_no_action, 4'b0000);
    chk("t1_jdo",  dbg.jdo, d1);
    chk("t1_pend", dbg.cmd_pending, 1'b1);
    tick(1);
    chk("t1_ta_off",   dbg.take_action, 4'b0000);
    chk("t1_pend_off", dbg.cmd_pending, 1'b0);

    // 2: acked channel 2 holds the second command until action_ack
    send(1'b0, 2'd2, d2a);
    chk("t2_ta_a",  dbg.take_action, 4'b0100);
    chk("t2_jdo_a", dbg.jdo, d2a);
    tick(1);
    send(1'b0, 2'd2, d2b);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dbg.take_action != 4'b0000) seen = 1'b1;
      tick(1);
    end
    chk("t2_held", seen, 1'b0);
    chk("t2_pend", dbg.cmd_pending, 1'b1);
    dbg.action_ack = 1'b1;
    tick(1);
    dbg.action_ack = 1'b0;
    chk("t2_ta_ack", dbg.take_action, 4'b0000);
    tick(1);
    chk("t2_ta_b",  dbg.take_action, 4'b0100);
    chk("t2_jdo_b", dbg.jdo, d2b);
    tick(1);
    dbg.action_ack = 1'b1;
    tick(1);
    dbg.action_ack = 1'b0;
    tick(1);
    chk("t2_pend_done", dbg.cmd_pending, 1'b0);

    // 3: overflow while stuck in WAIT_ACK
    send(1'b0, 2'd2, d3[0]);
    chk("t3_ta0", dbg.take_action, 4'b0100);
    for (int k = 1; k < 5; k++) send(1'b0, 2'd2, d3[k]);
    chk("t3_ovf_full", dbg.overflow, 1'b0);
    send(1'b0, 2'd2, d3[5]);
    chk("t3_ovf_drop", dbg.overflow, 1'b1);
    chk("t3_pend",     dbg.cmd_pending, 1'b1);
    dbg.clr_err = 1'b1;
    tick(1);
    dbg.clr_err = 1'b0;
    chk("t3_ovf_clr", dbg.overflow, 1'b0);
    for (int k = 1; k < 5; k++) begin
      dbg.action_ack = 1'b1;
      tick(1);
      dbg.action_ack = 1'b0;
      tick(1);
      chk("t3_drain_ta",  dbg.take_action, 4'b0100);
      chk("t3_drain_jdo", dbg.jdo, d3[k]);
      tick(1);
    end
    dbg.action_ack = 1'b1;
    tick(1);
    dbg.action_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (dbg.take_action != 4'b0000 || dbg.cmd_pending != 1'b0) seen = 1'b1;
    end
    chk("t3_empty", seen, 1'b0);

    // 4: simultaneous UDR/UIR edges, then a UIR-only command
    dbg.ir_in  = 2'd1;
    dbg.sr     = x1;
    dbg.vs_udr = 1'b1;
    dbg.vs_uir = 1'b1;
    tick(2);
    dbg.vs_udr = 1'b0;
    dbg.vs_uir = 1'b0;
    tick(2);
    chk("t4_ta",  dbg.take_action, 4'b0010);
    chk("t4_tna", dbg.take_no_action, 4'b0000);
    chk("t4_ovf", dbg.overflow, 1'b1);
    chk("t4_jdo", dbg.jdo, x1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (dbg.take_no_action != 4'b0000) seen = 1'b1;
    end
    chk("t4_uir_lost", seen, 1'b0);
    dbg.clr_err = 1'b1;
    tick(1);
    dbg.clr_err = 1'b0;
    chk("t4_ovf_clr", dbg.overflow, 1'b0);
    send(1'b1, 2'd3, 38'h3F_FFFF_FFFF);
    chk("t4_uir_tna", dbg.take_no_action, 4'b1000);
    chk("t4_uir_ta",  dbg.take_action, 4'b0000);
    chk("t4_uir_jdo", dbg.jdo, x1);
    tick(2);

    // 5: reset with 3 queued entries and vs_udr held high across reset
    send(1'b0, 2'd2, d3[0]);
    for (int k = 1; k < 4; k++) send(1'b0, 2'd2, d3[k]);
    chk("t5_pend_pre", dbg.cmd_pending, 1'b1);
    dbg.vs_udr = 1'b1;
    reset      = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_ta",   dbg.take_action, 4'b0000);
    chk("t5_tna",  dbg.take_no_action, 4'b0000);
    chk("t5_jdo",  dbg.jdo, 38'h0);
    chk("t5_pend", dbg.cmd_pending, 1'b0);
    chk("t5_ovf",  dbg.overflow, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (dbg.take_action != 4'b0000 || dbg.take_no_action != 4'b0000 ||
          dbg.cmd_pending != 1'b0) seen = 1'b1;
    end
    chk("t5_quiet", seen, 1'b0);
    dbg.vs_udr = 1'b0;
    tick(3);
    send(1'b0, 2'd1, y);
    chk("t5_post_ta",  dbg.take_action, 4'b0010);
    chk("t5_post_jdo", dbg.jdo, y);
    tick(2);

    // 6: odd-parity data word
    send(1'b0, 2'd1, 38'h1);
`ifdef DBG_CMD_PARITY_EN
    chk("t6_bad_ta",  dbg.take_action, 4'b0000);
    chk("t6_bad_par", dbg.parity_err, 1'b1);
    chk("t6_bad_jdo", dbg.jdo, y);
    tick(1);
    chk("t6_bad_idle", dbg.cmd_pending, 1'b0);
    chk("t6_bad_ta2",  dbg.take_action, 4'b0000);
`else
    chk("t6_nochk_ta",  dbg.take_action, 4'b0010);
    chk("t6_nochk_jdo", dbg.jdo, 38'h1);
    chk("t6_nochk_par", dbg.parity_err, 1'b0);
    tick(1);
`endif
    tick(1);
    send(1'b0, 2'd1, 38'h6);
    chk("t6_good_ta",  dbg.take_action, 4'b0010);
    chk("t6_good_jdo", dbg.jdo, 38'h6);
`ifdef DBG_CMD_PARITY_EN
    chk("t6_par_sticky", dbg.parity_err, 1'b1);
    dbg.clr_err = 1'b1;
    tick(1);
    dbg.clr_err = 1'b0;
    chk("t6_par_clr", dbg.parity_err, 1'b0);
`else
    chk("t6_par_zero", dbg.parity_err, 1'b0);
`endif
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
